// File: rtl/uart_line_pkg.sv
// Shared types and character constants for the UART line capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_line_pkg;

  // Output register occupancy.
  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

  // Classification of the character presented this cycle.
  typedef enum logic [1:0] {
    CH_DATA,
    CH_TERM,
    CH_BS,
    CH_NONE
  } char_class_t;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

endpackage

// File: rtl/uart_line_outreg.sv
// One-entry line holding register with valid/ready handoff and drop reporting.
// Latency: a completion is visible on line_* one edge later.
// Backpressure: a completion arriving while full and not ready is discarded and pulses line_dropped.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   done              a line completes this cycle (in_* hold its contents)
//   in_data/len/ovf   completed line contents from the working buffer
//   line_*            held line, valid flag, consumer ready, drop pulse
module uart_line_outreg
  import uart_line_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int CHARACTER_COUNT = 10,
  parameter int LEN_WIDTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  done,
  input  logic [DATA_WIDTH*CHARACTER_COUNT-1:0] in_data,
  input  logic [LEN_WIDTH-1:0]                  in_len,
  input  logic                                  in_ovf,
  output logic [DATA_WIDTH*CHARACTER_COUNT-1:0] line_data,
  output logic [LEN_WIDTH-1:0]                  line_len,
  output logic                                  line_overflow,
  output logic                                  line_valid,
  input  logic                                  line_ready,
  output logic                                  line_dropped
);

  out_state_t state, state_nxt;
  logic       load;
  logic       drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      OUT_EMPTY: begin
        if (done) begin
          load      = 1'b1;
          state_nxt = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (done) begin
          // Handoff and refill on the same edge avoids a bubble; otherwise
          // the held line has priority and the new one is lost.
          if (line_ready) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (line_ready) begin
          state_nxt = OUT_EMPTY;
        end
      end
      default: state_nxt = OUT_EMPTY;
    endcase
  end

  // Contents only change on load, so they stay stable while valid and keep
  // the last line after handoff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_data     <= '0;
      line_len      <= '0;
      line_overflow <= 1'b0;
      line_dropped  <= 1'b0;
    end else begin
      line_dropped <= drop;
      if (load) begin
        line_data     <= in_data;
        line_len      <= in_len;
        line_overflow <= in_ovf;
      end
    end
  end

  assign line_valid = (state == OUT_FULL);

endmodule

// File: rtl/uart_line_capture.sv
// Assembles UART characters into lines with backspace editing; hands completed lines downstream.
// Latency: sr_data updates 1 edge after an accepted char; line_* update 1 edge after the terminator.
// Backpressure: none toward rx (one char/cycle always accepted); lines completing while the output is held are dropped.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   ena                 gates character acceptance (handshake keeps running)
//   rx_data, rx_valid   received character and its one-cycle strobe
//   sr_data             live working buffer, char 0 is newest
//   line_data/len/overflow/valid, line_ready, line_dropped   captured line handoff
module uart_line_capture
  import uart_line_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    CHARACTER_COUNT = 10,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR      = DATA_WIDTH'(ASCII_CR),
  parameter logic [DATA_WIDTH-1:0] BACKSPACE       = DATA_WIDTH'(ASCII_BS),
  parameter bit                    EDIT_EN         = 1'b1,
  parameter bit                    EMPTY_LINES     = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ena,
  input  logic [DATA_WIDTH-1:0]                  rx_data,
  input  logic                                   rx_valid,
  output logic [DATA_WIDTH*CHARACTER_COUNT-1:0]  sr_data,
  output logic [DATA_WIDTH*CHARACTER_COUNT-1:0]  line_data,
  output logic [$clog2(CHARACTER_COUNT+1)-1:0]   line_len,
  output logic                                   line_overflow,
  output logic                                   line_valid,
  input  logic                                   line_ready,
  output logic                                   line_dropped
);

  localparam int             N       = CHARACTER_COUNT;
  localparam int             DW      = DATA_WIDTH;
  localparam int             LW      = $clog2(CHARACTER_COUNT + 1);
  localparam logic [LW-1:0]  CNT_MAX = LW'(N);

  logic [DW*N-1:0] sr;
  logic [LW-1:0]   cnt;
  logic            ovf;
  char_class_t     ch_class;
  logic            line_done;

  // Terminator wins over backspace so a shared code still ends the line.
  always_comb begin
    ch_class = CH_NONE;
    if (ena && rx_valid) begin
      if (rx_data == TERMINATOR) begin
        ch_class = CH_TERM;
      end else if (EDIT_EN && (rx_data == BACKSPACE)) begin
        ch_class = CH_BS;
      end else begin
        ch_class = CH_DATA;
      end
    end
  end

  assign line_done = (ch_class == CH_TERM) && ((cnt != '0) || EMPTY_LINES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      case (ch_class)
        CH_DATA: begin
          // Newest char enters at index 0; when full the oldest falls off the top.
          sr <= {sr[DW*(N-1)-1:0], rx_data};
          if (cnt < CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end else begin
            ovf <= 1'b1;
          end
        end
        CH_BS: begin
          if (cnt != '0) begin
            sr  <= {{DW{1'b0}}, sr[DW*N-1:DW]};
            cnt <= cnt - 1'b1;
          end
        end
        CH_TERM: begin
          if (line_done) begin
            sr  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sr_data = sr;

  uart_line_outreg #(
    .DATA_WIDTH      (DW),
    .CHARACTER_COUNT (N),
    .LEN_WIDTH       (LW)
  ) u_outreg (
    .clk           (clk),
    .reset         (reset),
    .done          (line_done),
    .in_data       (sr),
    .in_len        (cnt),
    .in_ovf        (ovf),
    .line_data     (line_data),
    .line_len      (line_len),
    .line_overflow (line_overflow),
    .line_valid    (line_valid),
    .line_ready    (line_ready),
    .line_dropped  (line_dropped)
  );

endmodule

// File: tb/tb_uart_line_capture.sv
// Self-checking bench for uart_line_capture with a 4-character buffer.
// Latency: n/a.
// Backpressure: exercised through line_ready.
module tb_uart_line_capture;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h08;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        line_ready = 1'b1;

  logic [31:0] sr_data, line_data;
  logic [2:0]  line_len;
  logic        line_overflow, line_valid, line_dropped;

  logic [31:0] el_sr_data, el_line_data;
  logic [2:0]  el_line_len;
  logic        el_line_overflow, el_line_valid, el_line_dropped;

  logic [31:0] ne_sr_data, ne_line_data;
  logic [2:0]  ne_line_len;
  logic        ne_line_overflow, ne_line_valid, ne_line_dropped;

  always #5 clk = ~clk;

  uart_line_capture #(.DATA_WIDTH(8), .CHARACTER_COUNT(4)) dut (
    .clk(clk), .reset(reset), .ena(ena), .rx_data(rx_data), .rx_valid(rx_valid),
    .sr_data(sr_data), .line_data(line_data), .line_len(line_len),
    .line_overflow(line_overflow), .line_valid(line_valid),
    .line_ready(line_ready), .line_dropped(line_dropped)
  );

  uart_line_capture #(.DATA_WIDTH(8), .CHARACTER_COUNT(4), .EMPTY_LINES(1'b1)) dut_el (
    .clk(clk), .reset(reset), .ena(ena), .rx_data(rx_data), .rx_valid(rx_valid),
    .sr_data(el_sr_data), .line_data(el_line_data), .line_len(el_line_len),
    .line_overflow(el_line_overflow), .line_valid(el_line_valid),
    .line_ready(line_ready), .line_dropped(el_line_dropped)
  );

  uart_line_capture #(.DATA_WIDTH(8), .CHARACTER_COUNT(4), .EDIT_EN(1'b0)) dut_ne (
    .clk(clk), .reset(reset), .ena(ena), .rx_data(rx_data), .rx_valid(rx_valid),
    .sr_data(ne_sr_data), .line_data(ne_line_data), .line_len(ne_line_len),
    .line_overflow(ne_line_overflow), .line_valid(ne_line_valid),
    .line_ready(line_ready), .line_dropped(ne_line_dropped)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  len;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   drop_cnt = 0;
  int   d0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    rx_data  = c;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_line(input logic [31:0] d, input logic [2:0] l, input logic o);
    exp_t e;
    e.data = d;
    e.len  = l;
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  // Scoreboard: a transfer happens on the next edge whenever valid && ready.
  always @(negedge clk) begin
    if (line_dropped) drop_cnt++;
    if (line_valid && line_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_line", 32'(line_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("line_data", line_data, mon_e.data);
        check("line_len", 32'(line_len), 32'(mon_e.len));
        check("line_overflow", 32'(line_overflow), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    idle(1);
    check("rst_sr_data", sr_data, 32'd0);
    check("rst_line_data", line_data, 32'd0);
    check("rst_line_len", 32'(line_len), 32'd0);
    check("rst_line_overflow", 32'(line_overflow), 32'd0);
    check("rst_line_valid", 32'(line_valid), 32'd0);
    check("rst_line_dropped", 32'(line_dropped), 32'd0);
    reset = 1'b0;

    // Asynchronous reset mid-line and mid-handshake.
    line_ready = 1'b0;
    send("Q");
    send(CR);
    send_str("XY");
    check("pre_rst_sr", sr_data, 32'h5859);
    check("pre_rst_valid", 32'(line_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_sr", sr_data, 32'd0);
    check("async_rst_valid", 32'(line_valid), 32'd0);
    check("async_rst_data", line_data, 32'd0);
    check("async_rst_len", 32'(line_len), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    line_ready = 1'b1;

    expect_line(32'h4142, 3'd2, 1'b0);
    send_str("AB");
    send(CR);
    idle(2);

    // Backspace editing, including on an empty buffer.
    send(BS);
    check("bs_empty_sr", sr_data, 32'd0);
    send_str("ABC");
    check("abc_sr", sr_data, 32'h414243);
    send(BS);
    send(BS);
    check("bs_bs_sr", sr_data, 32'h41);
    expect_line(32'h4144, 3'd2, 1'b0);
    send("D");
    send(CR);
    idle(2);

    // Overflow keeps the newest four; the flag does not leak into the next line.
    expect_line(32'h43444546, 3'd4, 1'b1);
    send_str("ABCDEF");
    send(CR);
    check("clear_after_cr", sr_data, 32'd0);
    expect_line(32'h58, 3'd1, 1'b0);
    send("X");
    send(CR);
    idle(2);

    // Handshake: held line survives, second line dropped, then no-bubble refill.
    line_ready = 1'b0;
    expect_line(32'h41, 3'd1, 1'b0);
    send("A");
    send(CR);
    idle(1);
    check("held_valid", 32'(line_valid), 32'd1);
    check("held_data", line_data, 32'h41);
    d0 = drop_cnt;
    send("B");
    send(CR);
    check("drop_pulse", 32'(line_dropped), 32'd1);
    check("drop_keeps_data", line_data, 32'h41);
    idle(1);
    check("drop_pulse_end", 32'(line_dropped), 32'd0);
    idle(1);
    check("drop_count", 32'(drop_cnt - d0), 32'd1);
    expect_line(32'h43, 3'd1, 1'b0);
    send("C");
    line_ready = 1'b1;
    send(CR);
    check("no_bubble_valid", 32'(line_valid), 32'd1);
    check("no_bubble_data", line_data, 32'h43);
    idle(2);

    // ena low: characters ignored, handshake still completes.
    line_ready = 1'b0;
    expect_line(32'h50, 3'd1, 1'b0);
    send("P");
    send(CR);
    send("K");
    check("k_sr", sr_data, 32'h4B);
    ena = 1'b0;
    line_ready = 1'b1;
    send_str("ZZ");
    check("ena_low_sr", sr_data, 32'h4B);
    check("ena_low_transfer", 32'(line_valid), 32'd0);
    ena = 1'b1;
    expect_line(32'h4B, 3'd1, 1'b0);
    send(CR);
    idle(3);

    // Parameter modes.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    line_ready = 1'b0;
    send(CR);
    check("empty_cr_ignored", 32'(line_valid), 32'd0);
    check("empty_line_valid", 32'(el_line_valid), 32'd1);
    check("empty_line_len", 32'(el_line_len), 32'd0);
    send("A");
    send(BS);
    send(CR);
    check("noedit_len", 32'(ne_line_len), 32'd2);
    check("noedit_data", ne_line_data, 32'h4108);
    check("edit_erased_no_line", 32'(line_valid), 32'd0);
    line_ready = 1'b1;
    idle(2);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_line_capture.md
# uart_line_capture

Parametrised successor to the UART character shift register. It accumulates received characters into a working line buffer, handles in-line backspace editing, and detects a terminator character. On a terminator it hands the completed line (data, length, overflow flag) to downstream logic through a one-entry valid/ready output register. It sits between the UART receiver (`rx_data`/`rx_valid`) and the command parser, so the parser sees whole lines instead of a raw character stream.

## Interface

- `DATA_WIDTH`, 8: bits per character.
- `CHARACTER_COUNT`, 10: line buffer depth in characters (N), ≥ 2.
- `TERMINATOR`, 8'h0D: character that ends a line; it is never stored.
- `BACKSPACE`, 8'h08: character that deletes the newest stored character.
- `EDIT_EN`, 1: 1 = BACKSPACE is interpreted; 0 = BACKSPACE is treated as data.
- `EMPTY_LINES`, 0: 1 = a terminator with count 0 delivers a zero-length line; 0 = it is ignored.

Ports:

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ena`  in  1  gates character acceptance only.
- `rx_data`  in  DATA_WIDTH  received character.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `sr_data`  out  DATA_WIDTH*N  live working buffer; char i at `[(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]`, index 0 newest.
- `line_data`  out  DATA_WIDTH*N  captured line, same layout as `sr_data`.
- `line_len`  out  $clog2(N+1)  number of valid characters in `line_data`.
- `line_overflow`  out  1  captured line exceeded N characters; only the newest N are kept.
- `line_valid`  out  1  output register holds a line.
- `line_ready`  in  1  consumer accepts the line.
- `line_dropped`  out  1  one-cycle pulse: a completed line was discarded.

## Operation

- Accept condition: `ena && rx_valid`. When `ena` is low, characters are ignored, but the output handshake still runs.
- Working state: `sr[N]`, `cnt` (0..N), `ovf`.
- Each accepted character is classified; the priority is TERMINATOR > BACKSPACE (only if EDIT_EN) > data. If TERMINATOR == BACKSPACE, the character acts as a terminator.
- Data character:
  - `sr[i] <= sr[i-1]` for i = 1..N-1, and `sr[0] <= rx_data`.
  - If cnt < N, then `cnt++`.
  - Else `cnt` stays at N and `ovf <= 1`; the oldest character is lost.
- Backspace:
  - If cnt > 0: `sr[i] <= sr[i+1]` for i = 0..N-2, `sr[N-1] <= 0`, and `cnt--`.
  - If cnt == 0: no effect.
  - `ovf` is unchanged.
- Terminator with cnt > 0, or with EMPTY_LINES = 1:
  - Line completes: capture `sr`, `cnt`, `ovf`.
  - Clear `sr` to 0, `cnt` to 0, `ovf` to 0.
- Terminator with cnt == 0 and EMPTY_LINES = 0: no effect.
- Output FSM (`out_state_t`):
  - **OUT_EMPTY** (`line_valid` = 0): on line completion → load the line, go to OUT_FULL.
  - **OUT_FULL** (`line_valid` = 1):
    - `line_ready` with no completion → OUT_EMPTY.
    - Completion with `line_ready` → load the new line, stay in OUT_FULL (no bubble).
    - Completion without `line_ready` → keep the held line, discard the new one, pulse `line_dropped`. The working buffer is still cleared.
- `line_data`, `line_len` and `line_overflow` are stable while `line_valid` is 1. Their value after handoff is don't-care, but the design holds the last line.

## Timing

- Reset value of every output is 0: `sr_data`, `line_data`, `line_len`, `line_overflow`, `line_valid`, `line_dropped`. The FSM resets to OUT_EMPTY.
- Reset mid-line or mid-handshake discards everything, immediately and asynchronously.
- `sr_data` reflects an accepted character on the next clock edge (latency 1).
- Terminator accepted in cycle t → `line_valid` and the line fields are updated at edge t+1.
- `line_dropped` is high for exactly the cycle after the discarding edge.
- A transfer occurs on an edge where `line_valid && line_ready`; `line_valid` falls at that edge unless a completion coincides.
- One character is processed per cycle at most; back-to-back `rx_valid` at full clock rate is supported.

## Structure

- Package `uart_line_pkg` holds:
  - `out_state_t` {OUT_EMPTY, OUT_FULL};
  - `char_class_t` {CH_DATA, CH_TERM, CH_BS, CH_NONE};
  - constants `ASCII_CR` = 8'h0D, `ASCII_LF` = 8'h0A, `ASCII_BS` = 8'h08, `ASCII_DEL` = 8'h7F.
- Sub-module `uart_line_outreg`: the output FSM plus the capture register and `line_dropped`. The top level holds the classifier and the working buffer.

## Test plan

All scenarios use N = 4 with default characters unless stated.

- Reset: assert `reset` asynchronously mid-line → all outputs 0 within the same cycle. After release, send "AB"+CR → `line_len` = 2, `line_data[7:0]` = 'B', `[15:8]` = 'A'.
- Backspace: send "ABC", BS, BS, "D", CR → `line_len` = 2, chars {'D','A'}, `line_overflow` = 0. A BS on an empty buffer leaves `cnt` = 0.
- Overflow: send "ABCDEF"+CR → `line_len` = 4, data newest-first {'F','E','D','C'}, `line_overflow` = 1. The next line "X"+CR has `line_overflow` = 0.
- Handshake: hold `line_ready` = 0, send "A"+CR, then "B"+CR → first line held, `line_dropped` pulses once. Send "C"+CR with `line_ready` = 1 at completion → `line_valid` stays 1, data = 'C'.
- Modes:
  - CR with an empty buffer, EMPTY_LINES = 0 → no `line_valid`.
  - CR with an empty buffer, EMPTY_LINES = 1 → `line_valid` with `line_len` = 0.
  - EDIT_EN = 0, send "A",BS,CR → `line_len` = 2, chars {8'h08,'A'}.
- `ena` low: `rx_valid` pulses with `ena` = 0 → `sr_data` unchanged, while a pending line still transfers on `line_ready`.
